// File: rtl/arbitro_comparador22_if.sv
// Requester/comparator bus for the shared comparator arbiter.
// The master side is the requester pool plus external comparator; the slave side is the arbiter.
interface arbitro_comparador22_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]   Req;
    logic [6*NUM_REQ-1:0] Valor;
    logic [NUM_REQ-1:0]   Ack;
    logic                 Resultado;
    logic [5:0]           CompEntrada;
    logic                 CompSalida;
    logic                 Ocupado;
    logic [CNT_W-1:0]     CuentaCoincidencias;

    modport master (
        output Req, Valor, CompSalida,
        input  Ack, Resultado, CompEntrada, Ocupado, CuentaCoincidencias
    );

    modport slave (
        input  Req, Valor, CompSalida,
        output Ack, Resultado, CompEntrada, Ocupado, CuentaCoincidencias
    );
endinterface

// File: rtl/arbitro_comparador22.sv
// Round-robin arbiter that time-shares one external 6-bit set-membership comparator
// among NUM_REQ requesters, returning a registered result with a one-cycle acknowledge.
module arbitro_comparador22 #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    arbitro_comparador22_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    localparam logic [1:0] INACTIVO = 2'd0;
    localparam logic [1:0] EVALUA   = 2'd1;
    localparam logic [1:0] RESPONDE = 2'd2;

    logic [1:0]           state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     winner_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic                 resultado_r;
    logic [5:0]           comp_entrada_r;
    logic                 ocupado_r;
    logic [CNT_W-1:0]     cuenta_r;

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     offset_s;
    logic [IDX_W-1:0]     win_s;
    logic [5:0]           win_val_s;

    // (a + b) mod NUM_REQ for indices already below NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Winner search: rotate Req so the pointer sits at bit 0, take the lowest set bit
    always_comb begin
        dbl_s    = {bus.Req, bus.Req} >> ptr_r;
        rot_s    = dbl_s[NUM_REQ-1:0];
        offset_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                offset_s = IDX_W'(k);
            end else begin
                offset_s = offset_s;
            end
        end
        win_s     = wrap_add(ptr_r, offset_s);
        win_val_s = 6'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_s) begin
                win_val_s = bus.Valor[6*i +: 6];
            end else begin
                win_val_s = win_val_s;
            end
        end
    end

    // Grant / evaluate / respond sequencer with saturating match counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r        <= INACTIVO;
            ptr_r          <= '0;
            winner_r       <= '0;
            ack_r          <= '0;
            resultado_r    <= 1'b0;
            comp_entrada_r <= 6'd0;
            ocupado_r      <= 1'b0;
            cuenta_r       <= '0;
        end else begin
            case (state_r)
                INACTIVO: begin
                    ack_r <= '0;
                    if (|bus.Req) begin
                        comp_entrada_r <= win_val_s;
                        winner_r       <= win_s;
                        ocupado_r      <= 1'b1;
                        state_r        <= EVALUA;
                    end else begin
                        ocupado_r      <= 1'b0;
                        state_r        <= INACTIVO;
                    end
                end
                EVALUA: begin
                    resultado_r <= bus.CompSalida;
                    if (bus.CompSalida && (cuenta_r != {CNT_W{1'b1}})) begin
                        cuenta_r <= cuenta_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cuenta_r <= cuenta_r;
                    end
                    ack_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_r;
                    ocupado_r <= 1'b1;
                    state_r   <= RESPONDE;
                end
                RESPONDE: begin
                    ack_r     <= '0;
                    ptr_r     <= wrap_add(winner_r, {{(IDX_W-1){1'b0}}, 1'b1});
                    ocupado_r <= 1'b0;
                    state_r   <= INACTIVO;
                end
                default: begin
                    ack_r     <= '0;
                    ocupado_r <= 1'b0;
                    state_r   <= INACTIVO;
                end
            endcase
        end
    end

    assign bus.Ack                 = ack_r;
    assign bus.Resultado           = resultado_r;
    assign bus.CompEntrada         = comp_entrada_r;
    assign bus.Ocupado             = ocupado_r;
    assign bus.CuentaCoincidencias = cuenta_r;
endmodule

// File: tb/tb_arbitro_comparador22.sv
// Directed bench for arbitro_comparador22: a table of single transactions plus
// hand-written sequences for latched value, abort on reset and counter saturation.
module tb_arbitro_comparador22;
    logic clk;
    logic rst;
    logic rst_small;
    logic [63:0] set_mask;
    int n_err;
    int n_chk;

    arbitro_comparador22_if #(.NUM_REQ(4), .CNT_W(8)) bus ();
    arbitro_comparador22_if #(.NUM_REQ(4), .CNT_W(2)) bus_s ();

    arbitro_comparador22 #(.NUM_REQ(4), .CNT_W(8)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );
    arbitro_comparador22 #(.NUM_REQ(4), .CNT_W(2)) dut_small (
        .Clk(clk), .Reset(rst_small), .bus(bus_s)
    );

    // Stand-in for the 22-number comparator: 13 and 62 are members, 0 and 7 are not
    assign bus.CompSalida   = set_mask[bus.CompEntrada];
    assign bus_s.CompSalida = set_mask[bus_s.CompEntrada];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst; int req; int v0; int v1; int v2; int v3;
        int ack; int res; int cnt;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input string name, input int eack, input int eres, input int ecnt);
        int lat;
        lat = 0;
        while (bus.Ack == 4'b0000 && lat < 8) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk({name, "_ack"}, 32'(bus.Ack), 32'(eack));
        chk({name, "_res"}, 32'(bus.Resultado), 32'(eres));
        chk({name, "_cnt"}, 32'(bus.CuentaCoincidencias), 32'(ecnt));
        step();
        chk({name, "_ack_width"}, 32'(bus.Ack), 32'd0);
    endtask

    initial begin
        vec_t tbl[7];
        int members[22];
        int exp6[5];
        int lat;

        members = '{1, 4, 9, 13, 16, 20, 22, 25, 28, 31, 33,
                    36, 39, 41, 44, 47, 50, 53, 55, 58, 60, 62};
        set_mask = 64'd0;
        for (int i = 0; i < 22; i++) set_mask[6'(members[i])] = 1'b1;

        tbl[0] = '{1, 1, 62, 0, 0, 0, 1, 1, 1};
        tbl[1] = '{0, 1, 0, 0, 0, 0, 1, 0, 1};
        tbl[2] = '{1, 15, 13, 0, 62, 7, 1, 1, 1};
        tbl[3] = '{0, 15, 13, 0, 62, 7, 2, 0, 1};
        tbl[4] = '{0, 15, 13, 0, 62, 7, 4, 1, 2};
        tbl[5] = '{0, 15, 13, 0, 62, 7, 8, 0, 2};
        tbl[6] = '{0, 15, 13, 0, 62, 7, 1, 1, 3};
        exp6 = '{1, 2, 3, 3, 3};

        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        rst_small = 1'b1;
        bus.Req = 4'd0;
        bus.Valor = 24'd0;
        bus_s.Req = 4'd0;
        bus_s.Valor = 24'd0;
        step();
        step();
        rst = 1'b0;
        rst_small = 1'b0;

        chk("rst_ack", 32'(bus.Ack), 32'd0);
        chk("rst_res", 32'(bus.Resultado), 32'd0);
        chk("rst_entrada", 32'(bus.CompEntrada), 32'd0);
        chk("rst_ocupado", 32'(bus.Ocupado), 32'd0);
        chk("rst_cnt", 32'(bus.CuentaCoincidencias), 32'd0);

        for (int r = 0; r < 7; r++) begin
            if (tbl[r].rst != 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            bus.Req   = 4'(tbl[r].req);
            bus.Valor = {6'(tbl[r].v3), 6'(tbl[r].v2), 6'(tbl[r].v1), 6'(tbl[r].v0)};
            run_txn($sformatf("row%0d", r), tbl[r].ack, tbl[r].res, tbl[r].cnt);
        end
        bus.Req = 4'd0;

        // Value changed and request dropped after the grant edge
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.Req   = 4'b0100;
        bus.Valor = {6'd0, 6'd62, 6'd0, 6'd0};
        step();
        chk("latch_ocupado", 32'(bus.Ocupado), 32'd1);
        chk("latch_entrada", 32'(bus.CompEntrada), 32'd62);
        bus.Valor = 24'd0;
        bus.Req   = 4'd0;
        step();
        chk("latch_ack", 32'(bus.Ack), 32'd4);
        chk("latch_res", 32'(bus.Resultado), 32'd1);
        chk("latch_cnt", 32'(bus.CuentaCoincidencias), 32'd1);
        step();
        chk("latch_ack_off", 32'(bus.Ack), 32'd0);
        chk("latch_idle", 32'(bus.Ocupado), 32'd0);
        chk("hold_entrada", 32'(bus.CompEntrada), 32'd62);
        chk("hold_res", 32'(bus.Resultado), 32'd1);

        // Reset in EVALUA abandons the transaction and rewinds the pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.Req   = 4'b0010;
        bus.Valor = {6'd0, 6'd0, 6'd62, 6'd0};
        run_txn("abort_pre", 2, 1, 1);
        bus.Req   = 4'b0100;
        bus.Valor = {6'd0, 6'd62, 6'd0, 6'd0};
        step();
        chk("abort_busy", 32'(bus.Ocupado), 32'd1);
        rst = 1'b1;
        bus.Req = 4'd0;
        step();
        rst = 1'b0;
        chk("abort_ack", 32'(bus.Ack), 32'd0);
        chk("abort_ocupado", 32'(bus.Ocupado), 32'd0);
        chk("abort_cnt", 32'(bus.CuentaCoincidencias), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort_noack%0d", i), 32'(bus.Ack), 32'd0);
        end
        bus.Req   = 4'b1010;
        bus.Valor = {6'd13, 6'd0, 6'd0, 6'd0};
        run_txn("abort_ptr", 2, 0, 0);
        bus.Req   = 4'b1000;
        run_txn("abort_req3", 8, 1, 1);
        bus.Req   = 4'd0;

        // Two-bit counter saturates at 3
        bus_s.Req   = 4'b0001;
        bus_s.Valor = {6'd0, 6'd0, 6'd0, 6'd62};
        for (int i = 0; i < 5; i++) begin
            lat = 0;
            while (bus_s.Ack == 4'b0000 && lat < 8) begin
                step();
                lat++;
            end
            chk($sformatf("sat_ack%0d", i), 32'(bus_s.Ack), 32'd1);
            chk($sformatf("sat_cnt%0d", i), 32'(bus_s.CuentaCoincidencias), 32'(exp6[i]));
            step();
        end
        bus_s.Req = 4'd0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
